sc_fifo_pkt_gen: RTL and testbench

Avalon-ST packet source that drives the 64-bit ingress port of the single-clock packet FIFO (`*_sc_fifo_in`) with self-describing test packets. It transmits a programmed number of packets of programmed length with a programmed inter-packet gap, and honours the FIFO's `ready` backpressure. Used in the E10 loopback datapath and in block-level benches as the traffic generator in front of the TX/RX FIFOs.

---
 rtl/sc_fifo_pkt_gen.sv | 210 +++++++++++++++++++++
 tb/tb_sc_fifo_pkt_gen.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo_pkt_gen.sv
// Avalon-ST test-packet source for the 64-bit single-clock FIFO ingress.
// Beats carry {seq, word index}; every output comes straight from a flop.
module sc_fifo_pkt_gen #(
  parameter int unsigned ERR_W = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic             cfg_start,
  input  logic             cfg_stop,
  input  logic [15:0]      cfg_pkt_len,
  input  logic [31:0]      cfg_num_pkts,
  input  logic [7:0]       cfg_ipg,
  input  logic             cfg_err_inject,
  output logic [63:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_startofpacket,
  output logic             out_endofpacket,
  output logic [2:0]       out_empty,
  output logic [ERR_W-1:0] out_error,
  output logic             sts_busy,
  output logic             sts_done,
  output logic [31:0]      sts_pkt_cnt
);

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_e;

  state_e             state_q, state_d;
  logic [12:0]        last_q, last_d;
  logic [2:0]         len_rem_q, len_rem_d;
  logic [31:0]        num_q, num_d;
  logic [7:0]         ipg_q, ipg_d;
  logic               inj_q, inj_d;
  logic               stop_q, stop_d;
  logic [7:0]         gap_q, gap_d;
  logic [31:0]        seq_q, seq_d;
  logic [12:0]        w_q, w_d;
  logic [31:0]        cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic               sop_q, sop_d;
  logic               eop_q, eop_d;
  logic [2:0]         empty_q, empty_d;
  logic [ERR_W-1:0]   error_q, error_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load_beat, clear_beat, beat_eop, beat_inj;
  logic [12:0]        nxt_w, nxt_last;
  logic [2:0]         beat_rem;

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    len_rem_d  = len_rem_q;
    num_d      = num_q;
    ipg_d      = ipg_q;
    inj_d      = inj_q;
    stop_d     = stop_q;
    gap_d      = gap_q;
    seq_d      = seq_q;
    w_d        = w_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    sop_d      = sop_q;
    eop_d      = eop_q;
    empty_d    = empty_q;
    error_d    = error_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    load_beat  = 1'b0;
    clear_beat = 1'b0;
    nxt_w      = w_q;
    nxt_last   = last_q;
    beat_rem   = len_rem_q;
    beat_inj   = inj_q;
    beat_eop   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cfg_start && (cfg_pkt_len != 16'd0)) begin
          // Beat 0 is built from the raw cfg inputs since the latches load this same edge.
          last_d    = 13'((cfg_pkt_len - 16'd1) >> 3);
          len_rem_d = cfg_pkt_len[2:0];
          num_d     = cfg_num_pkts;
          ipg_d     = cfg_ipg;
          inj_d     = cfg_err_inject;
          stop_d    = 1'b0;
          cnt_d     = 32'd0;
          seq_d     = 32'd0;
          busy_d    = 1'b1;
          state_d   = StSend;
          load_beat = 1'b1;
          nxt_w     = 13'd0;
          nxt_last  = last_d;
          beat_rem  = cfg_pkt_len[2:0];
          beat_inj  = cfg_err_inject;
        end
      end
      StSend: begin
        if (cfg_stop) stop_d = 1'b1;
        if (valid_q && out_ready) begin
          if (eop_q) begin
            cnt_d = cnt_q + 32'd1;
            seq_d = seq_q + 32'd1;
            if (((num_q != 32'd0) && (cnt_d == num_q)) || stop_q || cfg_stop) begin
              state_d    = StIdle;
              busy_d     = 1'b0;
              done_d     = 1'b1;
              clear_beat = 1'b1;
            end else if (ipg_q != 8'd0) begin
              state_d    = StGap;
              gap_d      = ipg_q;
              clear_beat = 1'b1;
            end else begin
              load_beat = 1'b1;
              nxt_w     = 13'd0;
            end
          end else begin
            load_beat = 1'b1;
            nxt_w     = w_q + 13'd1;
          end
        end
      end
      StGap: begin
        if (cfg_stop) begin
          state_d = StIdle;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (gap_q == 8'd1) begin
          state_d   = StSend;
          load_beat = 1'b1;
          nxt_w     = 13'd0;
        end else begin
          gap_d = gap_q - 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    if (load_beat) begin
      beat_eop = (nxt_w == nxt_last);
      valid_d  = 1'b1;
      w_d      = nxt_w;
      sop_d    = (nxt_w == 13'd0);
      eop_d    = beat_eop;
      empty_d  = beat_eop ? (3'd0 - beat_rem) : 3'd0;
      error_d  = (beat_eop && beat_inj) ? {ERR_W{1'b1}} : {ERR_W{1'b0}};
    end else if (clear_beat) begin
      valid_d = 1'b0;
      w_d     = 13'd0;
      sop_d   = 1'b0;
      eop_d   = 1'b0;
      empty_d = 3'd0;
      error_d = {ERR_W{1'b0}};
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q   <= StIdle;
      last_q    <= 13'd0;
      len_rem_q <= 3'd0;
      num_q     <= 32'd0;
      ipg_q     <= 8'd0;
      inj_q     <= 1'b0;
      stop_q    <= 1'b0;
      gap_q     <= 8'd0;
      seq_q     <= 32'd0;
      w_q       <= 13'd0;
      cnt_q     <= 32'd0;
      valid_q   <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      empty_q   <= 3'd0;
      error_q   <= {ERR_W{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      len_rem_q <= len_rem_d;
      num_q     <= num_d;
      ipg_q     <= ipg_d;
      inj_q     <= inj_d;
      stop_q    <= stop_d;
      gap_q     <= gap_d;
      seq_q     <= seq_d;
      w_q       <= w_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      empty_q   <= empty_d;
      error_q   <= error_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign out_data          = {seq_q, 19'd0, w_q};
  assign out_valid         = valid_q;
  assign out_startofpacket = sop_q;
  assign out_endofpacket   = eop_q;
  assign out_empty         = empty_q;
  assign out_error         = error_q;
  assign sts_busy          = busy_q;
  assign sts_done          = done_q;
  assign sts_pkt_cnt       = cnt_q;

endmodule

// File: tb/tb_sc_fifo_pkt_gen.sv
// Directed bench for sc_fifo_pkt_gen: expected beats are queued at start of
// each run and popped by a negedge monitor on every accepted beat.
module tb_sc_fifo_pkt_gen;

  localparam int unsigned ErrW = 6;

  logic            clk_clk = 1'b0;
  logic            reset_reset_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic            cfg_stop = 1'b0;
  logic [15:0]     cfg_pkt_len = 16'd0;
  logic [31:0]     cfg_num_pkts = 32'd0;
  logic [7:0]      cfg_ipg = 8'd0;
  logic            cfg_err_inject = 1'b0;
  logic [63:0]     out_data;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic            out_startofpacket;
  logic            out_endofpacket;
  logic [2:0]      out_empty;
  logic [ErrW-1:0] out_error;
  logic            sts_busy;
  logic            sts_done;
  logic [31:0]     sts_pkt_cnt;

  sc_fifo_pkt_gen #(.ERR_W(ErrW)) dut (
    .clk_clk           (clk_clk),
    .reset_reset_n     (reset_reset_n),
    .cfg_start         (cfg_start),
    .cfg_stop          (cfg_stop),
    .cfg_pkt_len       (cfg_pkt_len),
    .cfg_num_pkts      (cfg_num_pkts),
    .cfg_ipg           (cfg_ipg),
    .cfg_err_inject    (cfg_err_inject),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_startofpacket (out_startofpacket),
    .out_endofpacket   (out_endofpacket),
    .out_empty         (out_empty),
    .out_error         (out_error),
    .sts_busy          (sts_busy),
    .sts_done          (sts_done),
    .sts_pkt_cnt       (sts_pkt_cnt)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic [63:0]     data;
    logic            sop;
    logic            eop;
    logic [2:0]      empty;
    logic [ErrW-1:0] err;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    done_cnt = 0;
  int    idle_cnt = 0;
  int    exp_gap = 0;
  bit    seen_eop = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pkt(input int seq, input int len, input bit inj);
    int nw;
    beat_t b;
    nw = (len + 7) / 8;
    for (int w = 0; w < nw; w++) begin
      b.data  = {seq[31:0], w[31:0]};
      b.sop   = (w == 0);
      b.eop   = (w == nw - 1);
      b.empty = b.eop ? 3'((8 - (len % 8)) % 8) : 3'd0;
      b.err   = (b.eop && inj) ? {ErrW{1'b1}} : {ErrW{1'b0}};
      exp_q.push_back(b);
    end
  endtask

  // Scoreboard pop, stall stability and inter-packet idle count.
  always @(negedge clk_clk) begin
    beat_t cur;
    beat_t expb;
    cur = {out_data, out_startofpacket, out_endofpacket, out_empty, out_error};
    if (!reset_reset_n) begin
      exp_q.delete();
      seen_eop   = 1'b0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) chk("stall_hold", cur, prev_beat);
      if (out_valid && seen_eop) begin
        chk("ipg_idle", idle_cnt, exp_gap);
        seen_eop = 1'b0;
      end
      if (out_valid && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL extra_beat observed=%0h expected=none", cur);
        end
        if (exp_q.size() > 0) begin
          expb = exp_q.pop_front();
          chk("beat", cur, expb);
        end
        if (out_endofpacket) begin
          seen_eop = 1'b1;
          idle_cnt = 0;
        end
      end else if (!out_valid) begin
        idle_cnt++;
      end
      if (sts_done) begin
        done_cnt++;
        seen_eop = 1'b0;
      end
      prev_stall = out_valid && !out_ready;
      prev_beat  = cur;
    end
  end

  task automatic start_run(input int len, input int num, input int ipg, input bit inj);
    @(posedge clk_clk);
    #1;
    cfg_pkt_len    = 16'(len);
    cfg_num_pkts   = 32'(num);
    cfg_ipg        = 8'(ipg);
    cfg_err_inject = inj;
    cfg_start      = 1'b1;
    @(posedge clk_clk);
    #1;
    cfg_start = 1'b0;
    chk("busy_rise", sts_busy, 1'b1);
    chk("first_sop", {out_valid, out_startofpacket}, 2'b11);
  endtask

  task automatic wait_done(input int budget, input bit rnd, input int exp_cnt);
    bit got;
    int d0;
    got = 1'b0;
    d0  = done_cnt;
    for (int i = 0; i < budget && !got; i++) begin
      @(posedge clk_clk);
      #1;
      if (sts_done) got = 1'b1;
      else if (rnd) out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    chk("done_seen", got, 1'b1);
    chk("busy_at_done", sts_busy, 1'b0);
    chk("valid_at_done", out_valid, 1'b0);
    chk("pkt_cnt", sts_pkt_cnt, 32'(exp_cnt));
    repeat (2) @(posedge clk_clk);
    #1;
    chk("done_once", done_cnt - d0, 1);
    chk("done_low", sts_done, 1'b0);
    chk("queue_drained", exp_q.size(), 0);
  endtask

  function automatic logic [127:0] all_outs();
    return {out_data, out_valid, out_startofpacket, out_endofpacket, out_empty, out_error,
            sts_busy, sts_done, sts_pkt_cnt};
  endfunction

  initial begin
    int lens[4];
    bit found;
    lens = '{1, 7, 9, 65};

    repeat (3) @(posedge clk_clk);
    #1;
    chk("reset_outs", all_outs(), 0);
    reset_reset_n = 1'b1;

    // Basic run: 3 x 64 bytes back to back
    exp_gap = 0;
    for (int p = 0; p < 3; p++) push_pkt(p, 64, 1'b0);
    start_run(64, 3, 0, 1'b0);
    wait_done(100, 1'b0, 3);

    // Odd lengths
    for (int k = 0; k < 4; k++) begin
      push_pkt(0, lens[k], 1'b0);
      start_run(lens[k], 1, 0, 1'b0);
      wait_done(50, 1'b0, 1);
    end

    // Backpressure with a 3-cycle gap
    exp_gap = 3;
    for (int p = 0; p < 2; p++) push_pkt(p, 100, 1'b0);
    start_run(100, 2, 3, 1'b0);
    wait_done(300, 1'b1, 2);

    // Error injection, 60 bytes
    exp_gap = 0;
    push_pkt(0, 60, 1'b1);
    start_run(60, 1, 0, 1'b1);
    wait_done(50, 1'b0, 1);

    // Continuous mode stopped mid packet 5
    for (int p = 0; p < 6; p++) push_pkt(p, 256, 1'b0);
    start_run(256, 0, 0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(posedge clk_clk);
      #1;
      if (out_valid && out_data == 64'h0000_0005_0000_0010) begin
        found    = 1'b1;
        cfg_stop = 1'b1;
        @(posedge clk_clk);
        #1;
        cfg_stop = 1'b0;
      end
    end
    chk("stop_point_seen", found, 1'b1);
    wait_done(200, 1'b0, 6);

    // Reset mid-packet
    push_pkt(0, 64, 1'b0);
    start_run(64, 1, 0, 1'b0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b0;
    #1;
    chk("midpkt_reset_outs", all_outs(), 0);
    repeat (2) @(posedge clk_clk);
    #1;
    reset_reset_n = 1'b1;

    // Zero-length start is ignored
    @(posedge clk_clk);
    #1;
    cfg_pkt_len  = 16'd0;
    cfg_num_pkts = 32'd1;
    cfg_start    = 1'b1;
    @(posedge clk_clk);
    #1;
    cfg_start = 1'b0;
    chk("len0_busy", sts_busy, 1'b0);
    chk("len0_valid", out_valid, 1'b0);

    // Starts during a run are ignored
    for (int p = 0; p < 2; p++) push_pkt(p, 32, 1'b0);
    start_run(32, 2, 0, 1'b0);
    for (int r = 0; r < 2; r++) begin
      @(posedge clk_clk);
      #1;
      cfg_pkt_len  = 16'd8;
      cfg_num_pkts = 32'd5;
      cfg_start    = 1'b1;
      @(posedge clk_clk);
      #1;
      cfg_start = 1'b0;
    end
    wait_done(50, 1'b0, 2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
